// File: rtl/branch_predictor.sv
// Bimodal branch predictor: a table of 2-bit saturating counters indexed by PC,
// with a sequential table-clear sweep and saturating branch/misprediction counters.
module branch_predictor #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ENTRIES    = 64
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [DATA_WIDTH-1:0] lookup_pc_in,
  input  logic                  lookup_en_in,
  input  logic                  feedback_in,
  input  logic [DATA_WIDTH-1:0] feedback_pc_in,
  input  logic                  taken_in,
  input  logic                  flush_in,
  input  logic                  clear_in,
  output logic                  pred_out,
  output logic                  ready_out,
  output logic [31:0]           branch_cnt_out,
  output logic [31:0]           mispred_cnt_out
);

  localparam int unsigned IdxW = $clog2(ENTRIES);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(ENTRIES - 1);

  typedef enum logic {StIdle, StClear} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] clr_idx_q;
  logic [1:0]      bht_q [ENTRIES];
  logic [31:0]     branch_cnt_q, branch_cnt_d;
  logic [31:0]     mispred_cnt_q, mispred_cnt_d;

  logic [IdxW-1:0] lookup_idx;
  logic [IdxW-1:0] fb_idx;
  logic            upd_en;
  logic [1:0]      fb_ctr;

  // Word-aligned PCs: drop the byte-offset bits, no tag so aliasing is expected.
  assign lookup_idx = lookup_pc_in[IdxW+1:2];
  assign fb_idx     = feedback_pc_in[IdxW+1:2];
  assign fb_ctr     = bht_q[fb_idx];
  assign upd_en     = feedback_in & ready_out;

  // Upper PC bits and byte offsets intentionally do not take part in indexing.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc_in[DATA_WIDTH-1:IdxW+2], lookup_pc_in[1:0],
                            feedback_pc_in[DATA_WIDTH-1:IdxW+2], feedback_pc_in[1:0]};

  // State register and clear-sweep index.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= StIdle;
      clr_idx_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StClear) begin
        clr_idx_q <= (clr_idx_q == LastIdx) ? '0 : clr_idx_q + 1'b1;
      end
    end
  end

  // Next-state logic: clear_in only matters in idle, so a sweep never restarts.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (clear_in) state_d = StClear;
      StClear: if (clr_idx_q == LastIdx) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs: predictions and updates are only served while idle.
  always_comb begin
    ready_out = (state_q == StIdle);
    pred_out  = lookup_en_in & ready_out & bht_q[lookup_idx][1];
  end

  // Counter table: sweep writes weak-not-taken, otherwise saturating train.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else if (state_q == StClear) begin
      bht_q[clr_idx_q] <= 2'b01;
    end else if (upd_en) begin
      if (taken_in && (fb_ctr != 2'b11)) begin
        bht_q[fb_idx] <= fb_ctr + 2'b01;
      end else if (!taken_in && (fb_ctr != 2'b00)) begin
        bht_q[fb_idx] <= fb_ctr - 2'b01;
      end
    end
  end

  // Statistics survive a table clear; both saturate at all-ones.
  assign branch_cnt_d  = (upd_en && (branch_cnt_q != '1)) ? branch_cnt_q + 32'd1 : branch_cnt_q;
  assign mispred_cnt_d = (flush_in && ready_out && (mispred_cnt_q != '1)) ?
                         mispred_cnt_q + 32'd1 : mispred_cnt_q;

  // Statistics registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_cnt_out  = branch_cnt_q;
  assign mispred_cnt_out = mispred_cnt_q;

endmodule
